// File: rtl/led_cmd_pkg.sv
// Shared command codes, show states and priority ranking for the LED command path.
// The LED FSM decodes the same CMD_* codes, so the state encoding reuses them directly.
package led_cmd_pkg;

   localparam logic [2:0] CMD_IDLE   = 3'b000;
   localparam logic [2:0] CMD_REFUND = 3'b001;
   localparam logic [2:0] CMD_COIN   = 3'b011;
   localparam logic [2:0] CMD_VEND   = 3'b101;
   localparam logic [2:0] CMD_FAULT  = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE   = CMD_IDLE,
      ST_REFUND = CMD_REFUND,
      ST_COIN   = CMD_COIN,
      ST_VEND   = CMD_VEND,
      ST_FAULT  = CMD_FAULT
   } state_t;

   // Higher rank wins; IDLE ranks below every real event.
   function automatic logic [2:0] prio_rank(input state_t s);
      case (s)
         ST_FAULT:  prio_rank = 3'd4;
         ST_REFUND: prio_rank = 3'd3;
         ST_VEND:   prio_rank = 3'd2;
         ST_COIN:   prio_rank = 3'd1;
         default:   prio_rank = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/led_tick_div.sv
// Free-running animation tick divider: pulses o_step_tick once every TICK_DIV clocks.
module led_tick_div #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_step_tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_div_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)                r_div_cnt <= '0;
      else if (r_div_cnt == LAST) r_div_cnt <= '0;
      else                       r_div_cnt <= r_div_cnt + 1'b1;
   end

   assign o_step_tick = (r_div_cnt == LAST);

endmodule

// File: rtl/led_cmd_gen.sv
// Turns single-cycle machine events into held LED pattern commands plus the animation tick.
// Define LED_CMD_QUEUE_EN to keep one lower-priority event pending behind the current show.
module led_cmd_gen
   import led_cmd_pkg::*;
#(
   parameter int TICK_DIV     = 4,
   parameter int COIN_TICKS   = 3,
   parameter int VEND_TICKS   = 4,
   parameter int REFUND_TICKS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ev_coin,
   input  logic       ev_vend,
   input  logic       ev_refund,
   input  logic       ev_fault,
   input  logic       fault_clr,
   output logic [2:0] cmd,
   output logic       step_tick,
   output logic       busy
);

   localparam int MAX_CV = (COIN_TICKS > VEND_TICKS) ? COIN_TICKS : VEND_TICKS;
   localparam int MAX_T  = (MAX_CV > REFUND_TICKS) ? MAX_CV : REFUND_TICKS;
   localparam int REM_W  = $clog2(MAX_T + 1);

   state_t           r_state;
   logic [REM_W-1:0] r_rem;
   logic [2:0]       r_cmd;
   logic             r_busy;

   state_t           w_ev;
   state_t           w_pend;
   state_t           w_nxt_state;
   logic [REM_W-1:0] w_nxt_rem;
   logic             w_step;
   logic             w_show_end;

   function automatic logic [REM_W-1:0] ticks_of(input state_t s);
      case (s)
         ST_COIN:   ticks_of = REM_W'(COIN_TICKS);
         ST_VEND:   ticks_of = REM_W'(VEND_TICKS);
         ST_REFUND: ticks_of = REM_W'(REFUND_TICKS);
         default:   ticks_of = '0;
      endcase
   endfunction

   led_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .o_step_tick (w_step)
   );

`ifdef LED_CMD_QUEUE_EN
   state_t r_pend;
   state_t w_nxt_pend;
   assign w_pend = r_pend;

   always_ff @(posedge clk) begin
      if (!rst_n) r_pend <= ST_IDLE;
      else        r_pend <= w_nxt_pend;
   end
`else
   assign w_pend = ST_IDLE;
`endif

   always_comb begin
      if (ev_fault)       w_ev = ST_FAULT;
      else if (ev_refund) w_ev = ST_REFUND;
      else if (ev_vend)   w_ev = ST_VEND;
      else if (ev_coin)   w_ev = ST_COIN;
      else                w_ev = ST_IDLE;
   end

   assign w_show_end = (r_state != ST_IDLE) && (r_state != ST_FAULT) && w_step && (r_rem == REM_W'(1));

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_rem   = r_rem;
`ifdef LED_CMD_QUEUE_EN
      w_nxt_pend  = r_pend;
`endif
      if (r_state == ST_FAULT) begin
         if (fault_clr) begin
            w_nxt_state = ST_IDLE;
            w_nxt_rem   = '0;
`ifdef LED_CMD_QUEUE_EN
            w_nxt_pend  = ST_IDLE;
`endif
         end
      end else if (r_state == ST_IDLE || w_show_end) begin
         // An ending show behaves like IDLE, except the pending entry competes with new events.
         if (prio_rank(w_ev) > prio_rank(w_pend)) begin
            w_nxt_state = w_ev;
            w_nxt_rem   = ticks_of(w_ev);
         end else begin
            w_nxt_state = w_pend;
            w_nxt_rem   = ticks_of(w_pend);
`ifdef LED_CMD_QUEUE_EN
            w_nxt_pend  = (w_ev != ST_IDLE && prio_rank(w_ev) < prio_rank(w_pend)) ? w_ev : ST_IDLE;
`endif
         end
      end else if (prio_rank(w_ev) >= prio_rank(r_state)) begin
         w_nxt_state = w_ev;
         w_nxt_rem   = ticks_of(w_ev);
      end else begin
         if (w_step) w_nxt_rem = r_rem - 1'b1;
`ifdef LED_CMD_QUEUE_EN
         if (w_ev != ST_IDLE && prio_rank(w_ev) >= prio_rank(r_pend)) w_nxt_pend = w_ev;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rem   <= '0;
         r_cmd   <= CMD_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_rem   <= w_nxt_rem;
         r_cmd   <= w_nxt_state;
         r_busy  <= (w_nxt_state != ST_IDLE);
      end
   end

   assign cmd       = r_cmd;
   assign busy      = r_busy;
   assign step_tick = w_step;

endmodule

// File: tb/tb_led_cmd_gen.sv
// Scoreboard bench for led_cmd_gen: per-cycle expected cmd/busy/step_tick are queued, then popped each cycle.
module tb_led_cmd_gen;
   import led_cmd_pkg::*;

   typedef struct packed {
      logic [2:0] cmd;
      logic       busy;
      logic       step;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ev_coin = 1'b0, ev_vend = 1'b0, ev_refund = 1'b0, ev_fault = 1'b0, fault_clr = 1'b0;
   logic [2:0] cmd;
   logic       step_tick, busy;

   exp_t exp_q[$];
   exp_t e;
   int   exp_phase = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   led_cmd_gen #(.TICK_DIV(4), .COIN_TICKS(3), .VEND_TICKS(4), .REFUND_TICKS(2)) dut (
      .clk(clk), .rst_n(rst_n), .ev_coin(ev_coin), .ev_vend(ev_vend), .ev_refund(ev_refund),
      .ev_fault(ev_fault), .fault_clr(fault_clr), .cmd(cmd), .step_tick(step_tick), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, vectors=%0d", n_vec);
      $fatal(1, "timeout");
   end

   task automatic push_exp(input logic [2:0] code, input int n);
      exp_t x;
      for (int i = 0; i < n; i++) begin
         x.cmd  = code;
         x.busy = (code != CMD_IDLE);
         x.step = ((exp_phase % 4) == 3);
         exp_phase++;
         exp_q.push_back(x);
      end
   endtask

   task automatic clear_inputs();
      ev_coin = 0; ev_vend = 0; ev_refund = 0; ev_fault = 0; fault_clr = 0;
   endtask

   // Leaves the bench at the falling edge of cycle 0, the first cycle with rst_n high.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      clear_inputs();
      repeat (3) @(negedge clk);
      rst_n = 1;
      exp_phase = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 0;
      ev_coin = 1; ev_fault = 1;
      repeat (3) @(negedge clk);
      clear_inputs();
      rst_n = 1;
      exp_phase = 0;
      push_exp(CMD_IDLE, 16);
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({cmd, busy, step_tick} !== {e.cmd, e.busy, e.step}) begin
            n_miss++;
            $display("FAIL reset c=%0d got cmd=%b busy=%b tick=%b want cmd=%b busy=%b tick=%b",
                     c, cmd, busy, step_tick, e.cmd, e.busy, e.step);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_coin();
      do_reset();
      push_exp(CMD_IDLE, 1); push_exp(CMD_COIN, 11); push_exp(CMD_IDLE, 3);
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({cmd, busy, step_tick} !== {e.cmd, e.busy, e.step}) begin
            n_miss++;
            $display("FAIL coin c=%0d got cmd=%b busy=%b tick=%b want cmd=%b busy=%b tick=%b",
                     c, cmd, busy, step_tick, e.cmd, e.busy, e.step);
         end
         ev_coin   = (c == 0);
         fault_clr = (c == 5);
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_preempt();
      do_reset();
      push_exp(CMD_IDLE, 1); push_exp(CMD_COIN, 2); push_exp(CMD_REFUND, 5); push_exp(CMD_IDLE, 3);
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({cmd, busy, step_tick} !== {e.cmd, e.busy, e.step}) begin
            n_miss++;
            $display("FAIL preempt c=%0d got cmd=%b busy=%b tick=%b want cmd=%b busy=%b tick=%b",
                     c, cmd, busy, step_tick, e.cmd, e.busy, e.step);
         end
         ev_coin   = (c == 0);
         ev_refund = (c == 2);
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_queue();
      do_reset();
      push_exp(CMD_IDLE, 1); push_exp(CMD_VEND, 15);
`ifdef LED_CMD_QUEUE_EN
      push_exp(CMD_COIN, 12);
`endif
      push_exp(CMD_IDLE, 3);
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({cmd, busy, step_tick} !== {e.cmd, e.busy, e.step}) begin
            n_miss++;
            $display("FAIL queue c=%0d got cmd=%b busy=%b tick=%b want cmd=%b busy=%b tick=%b",
                     c, cmd, busy, step_tick, e.cmd, e.busy, e.step);
         end
         ev_vend = (c == 0);
         ev_coin = (c == 4);
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_fault();
      do_reset();
      push_exp(CMD_IDLE, 1); push_exp(CMD_VEND, 4); push_exp(CMD_FAULT, 86); push_exp(CMD_IDLE, 6);
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({cmd, busy, step_tick} !== {e.cmd, e.busy, e.step}) begin
            n_miss++;
            $display("FAIL fault c=%0d got cmd=%b busy=%b tick=%b want cmd=%b busy=%b tick=%b",
                     c, cmd, busy, step_tick, e.cmd, e.busy, e.step);
         end
         ev_vend   = (c == 0) || (c == 4) || (c == 30) || (c == 50);
         ev_coin   = (c == 2) || (c == 10) || (c == 50);
         ev_fault  = (c == 4) || (c == 40) || (c == 50);
         ev_refund = (c == 20) || (c == 50);
         fault_clr = (c == 90) || (c == 93);
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_retrigger();
      do_reset();
      push_exp(CMD_IDLE, 1); push_exp(CMD_VEND, 23); push_exp(CMD_IDLE, 3);
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({cmd, busy, step_tick} !== {e.cmd, e.busy, e.step}) begin
            n_miss++;
            $display("FAIL retrigger c=%0d got cmd=%b busy=%b tick=%b want cmd=%b busy=%b tick=%b",
                     c, cmd, busy, step_tick, e.cmd, e.busy, e.step);
         end
         ev_vend = (c == 0) || (c == 8);
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_show();
      do_reset();
      push_exp(CMD_IDLE, 1); push_exp(CMD_COIN, 5);
      exp_phase = 0;
      push_exp(CMD_IDLE, 8);
      for (int c = 0; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({cmd, busy, step_tick} !== {e.cmd, e.busy, e.step}) begin
            n_miss++;
            $display("FAIL reset_mid c=%0d got cmd=%b busy=%b tick=%b want cmd=%b busy=%b tick=%b",
                     c, cmd, busy, step_tick, e.cmd, e.busy, e.step);
         end
         ev_coin = (c == 0);
         rst_n   = (c != 5);
         @(negedge clk);
      end
      clear_inputs();
      rst_n = 1;
   endtask

   initial begin
      test_reset();
      test_coin();
      test_preempt();
      test_queue();
      test_fault();
      test_retrigger();
      test_reset_mid_show();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
